// File: rtl/axi_resp_pkg.sv
// Shared AXI4 responder types: bus widths, response codes, FSM state enums.
// Pure declarations; no latency or flow-control behaviour of its own.
package axi_resp_pkg;

    localparam int ID_W       = 4;
    localparam int ADDR_W     = 32;
    localparam int BEAT_BYTES = 64;
    localparam int DATA_W     = BEAT_BYTES * 8;
    localparam int STRB_W     = BEAT_BYTES;
    localparam int MAX_LEN    = 63;

    localparam logic [2:0] BEAT_SIZE = 3'b110;
    localparam logic [1:0] OKAY      = 2'b00;
    localparam logic [1:0] SLVERR    = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // A burst is refused when it runs past the end of its 4 KB page or is not full-width.
    function automatic logic burst_err(input logic [5:0] line_lo,
                                       input logic [7:0] len,
                                       input logic [2:0] size);
        logic [8:0] last_idx;
        last_idx = {3'b000, line_lo} + {1'b0, len};
        return (last_idx > 9'(MAX_LEN)) || (size != BEAT_SIZE);
    endfunction

endpackage

// File: rtl/axi4_bus_t.sv
// AXI4 bus bundle (AW, W, B, AR, R); the master modport is the responder's view.
// Wires only: no latency, flow control is the plain valid/ready handshake.
interface axi4_bus_t;

    logic [axi_resp_pkg::ID_W-1:0]   awid;
    logic [axi_resp_pkg::ADDR_W-1:0] awaddr;
    logic [7:0]                      awlen;
    logic [2:0]                      awsize;
    logic                            awvalid;
    logic                            awready;

    logic [axi_resp_pkg::DATA_W-1:0] wdata;
    logic [axi_resp_pkg::STRB_W-1:0] wstrb;
    logic                            wlast;
    logic                            wvalid;
    logic                            wready;

    logic [axi_resp_pkg::ID_W-1:0]   bid;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;

    logic [axi_resp_pkg::ID_W-1:0]   arid;
    logic [axi_resp_pkg::ADDR_W-1:0] araddr;
    logic [7:0]                      arlen;
    logic [2:0]                      arsize;
    logic                            arvalid;
    logic                            arready;

    logic [axi_resp_pkg::ID_W-1:0]   rid;
    logic [axi_resp_pkg::DATA_W-1:0] rdata;
    logic [1:0]                      rresp;
    logic                            rlast;
    logic                            rvalid;
    logic                            rready;

    modport master (
        input  awid, awaddr, awlen, awsize, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arvalid,
        input  rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_mem_array.sv
// DEPTH x 512-bit line store: byte-enabled synchronous write, asynchronous read.
// Read returns pre-write contents in a same-line collision; no backpressure, never reset.
module axi_mem_array
    import axi_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int LINE_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic [LINE_W-1:0] rd_line,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_line][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
    end

    assign rd_dat = mem[rd_line];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder with independent write and read FSMs over axi_mem_array.
// Latency 1 cycle AW->wready, AR->rvalid, last W->bvalid; outputs hold while the master stalls.
module axi_mem_responder
    import axi_resp_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    axi4_bus_t.master   axi,
    output logic [31:0] wr_beats,
    output logic [31:0] rd_beats,
    output logic [15:0] err_count
);

    localparam int LINE_W = $clog2(DEPTH);

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    // Holds the address channels closed for the first cycle out of reset.
    logic              run_en;
    logic [ID_W-1:0]   w_id, r_id;
    logic [LINE_W-1:0] w_line, r_line;
    logic              w_err, r_err;
    logic [7:0]        r_cnt;
    logic [DATA_W-1:0] mem_rd_dat;

    logic [LINE_W-1:0] aw_line, ar_line;
    logic              aw_err, ar_err;
    logic              aw_hs, w_hs, ar_hs, r_hs;
    logic [16:0]       err_sum;
    logic              unused_addr_bits;

    assign aw_line = axi.awaddr[6 +: LINE_W];
    assign ar_line = axi.araddr[6 +: LINE_W];
    assign aw_err  = burst_err(aw_line[5:0], axi.awlen, axi.awsize);
    assign ar_err  = burst_err(ar_line[5:0], axi.arlen, axi.arsize);

    assign unused_addr_bits = ^{axi.awaddr[5:0], axi.awaddr[ADDR_W-1:LINE_W+6],
                                axi.araddr[5:0], axi.araddr[ADDR_W-1:LINE_W+6]};

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid  && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;
    assign r_hs  = axi.rvalid  && axi.rready;

    always_comb begin
        w_state_nxt = w_state;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                axi.awready = run_en;
                if (axi.awvalid && run_en) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                axi.wready = 1'b1;
                if (axi.wvalid && axi.wlast) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                axi.bvalid = 1'b1;
                if (axi.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                axi.arready = run_en;
                if (axi.arvalid && run_en) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                axi.rvalid = 1'b1;
                if (axi.rready && r_cnt == 8'd0) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // AW and AR may both flag an error in one cycle, so the counter can step by two.
    assign err_sum = {1'b0, err_count} + 17'(aw_hs && aw_err) + 17'(ar_hs && ar_err);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            run_en    <= 1'b0;
            w_id      <= '0;
            r_id      <= '0;
            w_line    <= '0;
            r_line    <= '0;
            w_err     <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            wr_beats  <= '0;
            rd_beats  <= '0;
            err_count <= '0;
        end else begin
            w_state   <= w_state_nxt;
            r_state   <= r_state_nxt;
            run_en    <= 1'b1;
            err_count <= err_sum[16] ? 16'hffff : err_sum[15:0];
            wr_beats  <= wr_beats + 32'(w_hs);
            rd_beats  <= rd_beats + 32'(r_hs);
            if (aw_hs) begin
                w_id   <= axi.awid;
                w_line <= aw_line;
                w_err  <= aw_err;
            end else if (w_hs) begin
                w_line <= w_line + 1'b1;
            end
            if (ar_hs) begin
                r_id   <= axi.arid;
                r_line <= ar_line;
                r_err  <= ar_err;
                r_cnt  <= axi.arlen;
            end else if (r_hs) begin
                r_line <= r_line + 1'b1;
                r_cnt  <= r_cnt - 8'd1;
            end
        end
    end

    axi_mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .wr_en   (w_hs && !w_err),
        .wr_line (w_line),
        .wr_dat  (axi.wdata),
        .wr_strb (axi.wstrb),
        .rd_line (r_line),
        .rd_dat  (mem_rd_dat)
    );

    assign axi.bid   = w_id;
    assign axi.bresp = w_err ? SLVERR : OKAY;
    assign axi.rid   = r_id;
    assign axi.rresp = r_err ? SLVERR : OKAY;
    assign axi.rlast = (r_state == R_DATA) && (r_cnt == 8'd0);
    assign axi.rdata = (r_state == R_DATA && !r_err) ? mem_rd_dat : '0;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder against a flat line-array reference model.
module tb_axi_mem_responder;
    import axi_resp_pkg::*;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wr_beats, rd_beats;
    logic [15:0] err_count;

    axi4_bus_t bus();

    axi_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .axi       (bus),
        .wr_beats  (wr_beats),
        .rd_beats  (rd_beats),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [511:0] mdl [DEPTH];
    logic [31:0] exp_wr = 0, exp_rd = 0, exp_err = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Page-crossing / size rule in plain arithmetic on the byte address.
    function automatic bit model_err(input logic [31:0] addr, input int len, input logic [2:0] size);
        int first;
        first = int'((addr / 64) % 64);
        return (first + len > 63) || (size != 3'b110);
    endfunction

    function automatic int line_of(input logic [31:0] addr, input int i);
        return int'(((addr / 64) + i) % DEPTH);
    endfunction

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [2:0] size);
        int t = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = size; bus.awvalid = 1'b1;
        while (!bus.awready && t < 50) begin @(negedge clk); t++; end
        chk("aw_rdy", 512'(bus.awready), 512'(1));
        if (model_err(addr, len, size)) exp_err++;
        @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [2:0] size);
        int t = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = size; bus.arvalid = 1'b1;
        while (!bus.arready && t < 50) begin @(negedge clk); t++; end
        chk("ar_rdy", 512'(bus.arready), 512'(1));
        if (model_err(addr, len, size)) exp_err++;
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    // mode 0: fixed dat/strb, 1: random data full strobe, 2: random data and strobe
    task automatic w_send(input logic [31:0] addr, input int nbeats, input bit err, input int mode,
                          input logic [511:0] dat, input logic [63:0] strb, input bit stall);
        logic [511:0] d;
        logic [63:0]  s;
        int t, ln;
        for (int i = 0; i < nbeats; i++) begin
            if (stall) begin
                while ($urandom_range(0, 3) == 0) begin bus.wvalid = 1'b0; @(negedge clk); end
            end
            d = (mode == 0) ? dat : rnd512();
            s = (mode == 0) ? strb : (mode == 1) ? '1 : {$urandom, $urandom};
            bus.wdata = d; bus.wstrb = s; bus.wlast = (i == nbeats - 1); bus.wvalid = 1'b1;
            t = 0;
            while (!bus.wready && t < 50) begin @(negedge clk); t++; end
            chk("w_rdy", 512'(bus.wready), 512'(1));
            if (!err) begin
                ln = line_of(addr, i);
                for (int b = 0; b < 64; b++) if (s[b]) mdl[ln][b*8 +: 8] = d[b*8 +: 8];
            end
            exp_wr++;
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic b_recv(input logic [3:0] id, input bit err);
        int hold = $urandom_range(0, 2);
        chk("b_vld", 512'(bus.bvalid), 512'(1));
        chk("bid", 512'(bus.bid), 512'(id));
        chk("bresp", 512'(bus.bresp), 512'(err ? 2'b10 : 2'b00));
        chk("wr_beats", 512'(wr_beats), 512'(exp_wr));
        chk("err_count_w", 512'(err_count), 512'(exp_err));
        repeat (hold) begin
            @(negedge clk);
            chk("b_hold", 512'(bus.bvalid), 512'(1));
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        chk("b_done", 512'(bus.bvalid), 512'(0));
    endtask

    // mode 0: rready always high, 1: toggling 1/0, 2: random
    task automatic r_recv(input logic [3:0] id, input logic [31:0] addr, input int len, input bit err, input int mode);
        logic [511:0] exp_d, held;
        bit stalled = 0;
        bit rr;
        int i = 0, t = 0;
        while (i <= len && t < 4 * (len + 1) + 20) begin
            exp_d = err ? '0 : mdl[line_of(addr, i)];
            chk("r_vld", 512'(bus.rvalid), 512'(1));
            chk("rdata", bus.rdata, exp_d);
            chk("rlast", 512'(bus.rlast), 512'(i == len));
            chk("rid", 512'(bus.rid), 512'(id));
            chk("rresp", 512'(bus.rresp), 512'(err ? 2'b10 : 2'b00));
            if (stalled) chk("r_hold", bus.rdata, held);
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
            bus.rready = rr;
            held = bus.rdata;
            stalled = !rr;
            if (rr) begin i++; exp_rd++; end
            @(negedge clk);
            t++;
        end
        bus.rready = 1'b0;
        chk("r_idle", 512'(bus.rvalid), 512'(0));
        chk("rd_beats", 512'(rd_beats), 512'(exp_rd));
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [2:0] size,
                               input int nbeats, input int mode, input logic [511:0] dat, input logic [63:0] strb,
                               input bit stall);
        bit e = model_err(addr, len, size);
        aw_send(id, addr, len, size);
        w_send(addr, nbeats, e, mode, dat, strb, stall);
        b_recv(id, e);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [2:0] size,
                              input int mode);
        bit e = model_err(addr, len, size);
        ar_send(id, addr, len, size);
        r_recv(id, addr, len, e, mode);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int len, nb;
        logic [2:0] sz;

        rst_n = 1'b0;
        bus.awvalid = 0; bus.wvalid = 0; bus.wlast = 0; bus.bready = 0; bus.arvalid = 0; bus.rready = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0;
        repeat (3) @(negedge clk);
        chk("rst_awready", 512'(bus.awready), 512'(0));
        chk("rst_arready", 512'(bus.arready), 512'(0));
        chk("rst_bvalid", 512'(bus.bvalid), 512'(0));
        chk("rst_rvalid", 512'(bus.rvalid), 512'(0));
        chk("rst_rdata", bus.rdata, '0);
        chk("rst_wr_beats", 512'(wr_beats), 512'(0));
        chk("rst_err_count", 512'(err_count), 512'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", 512'(bus.awready), 512'(1));
        chk("post_rst_arready", 512'(bus.arready), 512'(1));

        for (int k = 0; k < DEPTH / 64; k++)
            write_burst(4'h0, 32'(k * 4096), 63, 3'b110, 64, 1, '0, '0, 0);

        // basic 4-beat write / read-back with fixed pattern
        aw_send(4'h3, 32'h0, 3, 3'b110);
        chk("aw2w_lat", 512'(bus.wready), 512'(1));
        w_send(32'h0, 4, 0, 0, {16{32'hA5A5_A5A5}}, '1, 0);
        b_recv(4'h3, 0);
        ar_send(4'h3, 32'h0, 3, 3'b110);
        chk("ar2r_lat", 512'(bus.rvalid), 512'(1));
        r_recv(4'h3, 32'h0, 3, 0, 0);

        read_burst(4'h1, 32'h0, 63, 3'b110, 1);

        // 4 KB crossing: beats accepted, memory untouched, SLVERR
        write_burst(4'h2, 32'(60 * 64), 7, 3'b110, 8, 1, '0, '0, 0);
        chk("err_count_one", 512'(err_count), 512'(1));
        read_burst(4'h2, 32'(60 * 64), 0, 3'b110, 0);

        write_burst(4'h4, 32'(100 * 64), 0, 3'b110, 1, 0, {64{8'hFF}}, '1, 0);
        write_burst(4'h4, 32'(100 * 64), 0, 3'b110, 1, 0, {64{8'h11}}, 64'h0000_0000_0000_000F, 0);
        read_burst(4'h4, 32'(100 * 64), 0, 3'b110, 0);

        // simultaneous AW/AR acceptance
        bus.awid = 4'h5; bus.awaddr = 32'(200 * 64); bus.awlen = 8'd1; bus.awsize = 3'b110; bus.awvalid = 1'b1;
        bus.arid = 4'h9; bus.araddr = 32'(10 * 64);  bus.arlen = 8'd2; bus.arsize = 3'b110; bus.arvalid = 1'b1;
        chk("dual_awready", 512'(bus.awready), 512'(1));
        chk("dual_arready", 512'(bus.arready), 512'(1));
        @(negedge clk);
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        chk("dual_wready", 512'(bus.wready), 512'(1));
        chk("dual_rvalid", 512'(bus.rvalid), 512'(1));
        fork
            begin
                w_send(32'(200 * 64), 2, 0, 2, '0, '0, 1);
                b_recv(4'h5, 0);
            end
            r_recv(4'h9, 32'(10 * 64), 2, 0, 2);
        join

        for (int n = 0; n < 40; n++) begin
            a   = {$urandom_range(0, 2 * DEPTH - 1), 6'($urandom)};
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
            sz  = ($urandom_range(0, 7) == 0) ? 3'b101 : 3'b110;
            if ($urandom_range(0, 1) == 0) begin
                nb = len + 1;
                if ($urandom_range(0, 3) == 0) nb = nb + $urandom_range(0, 3) - 1;
                if (nb < 1) nb = 1;
                write_burst(4'($urandom), a, len, sz, nb, 2, '0, '0, 1);
            end else begin
                read_burst(4'($urandom), a, len, sz, 2);
            end
        end

        // reset in the middle of a read burst
        ar_send(4'h7, 32'(5 * 64), 7, 3'b110);
        bus.rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.rready = 1'b0;
        @(negedge clk);
        chk("mid_rst_rvalid", 512'(bus.rvalid), 512'(0));
        chk("mid_rst_rd_beats", 512'(rd_beats), 512'(0));
        chk("mid_rst_arready", 512'(bus.arready), 512'(0));
        chk("mid_rst_err_count", 512'(err_count), 512'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_arready_up", 512'(bus.arready), 512'(1));
        chk("mid_rst_rvalid_idle", 512'(bus.rvalid), 512'(0));
        exp_wr = 0; exp_rd = 0; exp_err = 0;

        read_burst(4'h6, 32'h0, 15, 3'b110, 2);
        read_burst(4'h6, 32'(100 * 64), 0, 3'b110, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
